// File: rtl/wrapper.sv
// rtl/wrapper.sv - fp16 full 2-D convolution engine with stream kernel/image inputs and stream result output
//
// Purpose: loads a K_DIM x K_DIM kernel (one column per beat) and an
// I_DIM x I_DIM image (one pixel per beat, row-major). It then produces the
// full convolution, (K_DIM+I_DIM-1)^2 fp16 results in row-major order.
// Each result is accumulated from +0, one kernel position per cycle.
//
// Ports:
//   clk, rstn                        clock, asynchronous active-high reset
//   img_in_*    (data/valid/last/ready)     image pixel stream slave
//   kernel_in_* (data/valid/last/ready)     kernel column stream slave, lane j = K[j][beat]
//   out_*       (data/valid/last/ready)     result stream master
//
// Build option: define WRAPPER_ROUND_NEAREST_EN for round-to-nearest-even
// in the multiplier and adder; otherwise both truncate toward zero.

module wrapper #(
    parameter int K_DIM  = 3,
    parameter int I_DIM  = 3,
    parameter int M_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [M_BITS-1:0]         img_in_data,
    input  logic                      img_in_valid,
    input  logic                      img_in_last,
    output logic                      img_in_ready,
    input  logic [K_DIM*M_BITS-1:0]   kernel_in_data,
    input  logic                      kernel_in_valid,
    input  logic                      kernel_in_last,
    output logic                      kernel_in_ready,
    output logic [M_BITS-1:0]         out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready
);

    localparam int O_DIM = K_DIM + I_DIM - 1;
    localparam int KK    = K_DIM * K_DIM;
    localparam int II    = I_DIM * I_DIM;
    localparam int KIW   = (KK > 1) ? $clog2(KK) : 1;
    localparam int IIW   = (II > 1) ? $clog2(II) : 1;

    localparam logic [15:0] KK_C  = 16'(KK);
    localparam logic [15:0] K_C   = 16'(K_DIM);
    localparam logic [15:0] KM1_C = 16'(K_DIM - 1);
    localparam logic [15:0] II_C  = 16'(II);
    localparam logic [15:0] OM1_C = 16'(O_DIM - 1);

`ifdef WRAPPER_ROUND_NEAREST_EN
    localparam bit ROUND_NEAREST = 1'b1;
`else
    localparam bit ROUND_NEAREST = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_LOAD_K  = 2'd0,
        S_LOAD_I  = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    // fp16 multiply: zero exponent flushes to zero, exponent 31 saturates.
    function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        logic [11:0] m;
        logic        g;
        logic        st;
        int          e;
        logic [15:0] r;
        s = a[15] ^ b[15];
        p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) begin
            m  = {1'b0, p[21:11]};
            g  = p[10];
            st = |p[9:0];
            e  = e + 1;
        end else begin
            m  = {1'b0, p[20:10]};
            g  = p[9];
            st = |p[8:0];
        end
        if (ROUND_NEAREST && g && (st || m[0])) begin
            m = m + 12'd1;
        end
        // Rounding can carry out to 2.0; renormalize.
        if (m[11]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
            r = {s, 15'd0};
        end else if (a[14:10] == 5'd31 || b[14:10] == 5'd31) begin
            r = {s, 15'h7C00};
        end else if (e <= 0) begin
            r = {s, 15'd0};
        end else if (e >= 31) begin
            r = {s, 15'h7C00};
        end else begin
            r = {s, e[4:0], m[9:0]};
        end
        return r;
    endfunction

    // fp16 add. The smaller operand is aligned into a 45-bit field wide
    // enough that no bits are lost (exponent gap is at most 30), so the
    // guard/sticky bits taken after normalization are exact.
    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
        logic [14:0] mag_a;
        logic [14:0] mag_b;
        logic [15:0] big;
        logic [15:0] sml;
        logic [10:0] sig_b;
        logic [10:0] sig_s;
        logic [44:0] al_b;
        logic [44:0] al_s;
        logic [44:0] sum;
        logic [11:0] m;
        logic        g;
        logic        st;
        int          d;
        int          p;
        int          sh;
        int          e;
        logic [15:0] r;
        mag_a = (a[14:10] == 5'd0) ? 15'd0 : a[14:0];
        mag_b = (b[14:10] == 5'd0) ? 15'd0 : b[14:0];
        if (mag_a >= mag_b) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        sig_b = (big[14:10] == 5'd0) ? 11'd0 : {1'b1, big[9:0]};
        sig_s = (sml[14:10] == 5'd0) ? 11'd0 : {1'b1, sml[9:0]};
        d     = int'(big[14:10]) - int'(sml[14:10]);
        al_b  = {1'b0, sig_b, 33'd0};
        al_s  = {1'b0, sig_s, 33'd0} >> d;
        sum   = (big[15] != sml[15]) ? (al_b - al_s) : (al_b + al_s);
        p = 0;
        for (int k = 0; k < 45; k++) begin
            if (sum[k]) begin
                p = k;
            end
        end
        sh = p - 10;
        m  = {1'b0, 11'(sum >> sh)};
        g  = |(sum & (45'd1 << (sh - 1)));
        st = |(sum & ~({45{1'b1}} << (sh - 1)));
        e  = p + int'(big[14:10]) - 43;
        if (ROUND_NEAREST && g && (st || m[0])) begin
            m = m + 12'd1;
        end
        if (m[11]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (a[14:10] == 5'd31 || b[14:10] == 5'd31) begin
            r = {big[15], 15'h7C00};
        end else if (sum == 45'd0) begin
            r = 16'h0000;
        end else if (e <= 0) begin
            r = {big[15], 15'd0};
        end else if (e >= 31) begin
            r = {big[15], 15'h7C00};
        end else begin
            r = {big[15], e[4:0], m[9:0]};
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic                kready_q, kready_d;
    logic                iready_q, iready_d;
    logic                ovalid_q, ovalid_d;
    logic                olast_q, olast_d;
    logic [M_BITS-1:0]   data_q, data_d;
    logic [M_BITS-1:0]   acc_q, acc_d;
    logic [M_BITS-1:0]   kern_q [KK];
    logic [M_BITS-1:0]   kern_d [KK];
    logic [M_BITS-1:0]   img_q [II];
    logic [M_BITS-1:0]   img_d [II];
    logic [15:0]         kcol_q, kcol_d;
    logic [15:0]         pix_q, pix_d;
    logic [15:0]         step_q, step_d;
    logic [15:0]         ki_q, ki_d;
    logic [15:0]         kj_q, kj_d;
    logic [15:0]         orow_q, orow_d;
    logic [15:0]         ocol_q, ocol_d;

    logic                k_hs;
    logic                i_hs;
    logic                o_hs;
    int                  r_img;
    int                  c_img;
    int                  img_idx;
    logic                in_rng;
    logic [M_BITS-1:0]   pix_v;
    logic [M_BITS-1:0]   kern_v;
    logic [M_BITS-1:0]   prod;
    logic [M_BITS-1:0]   acc_sum;

    // Handshakes use the registered readies so nothing transfers in the
    // first cycle after reset release.
    assign k_hs = kernel_in_valid & kready_q;
    assign i_hs = img_in_valid & iready_q;
    assign o_hs = ovalid_q & out_ready;

    // Datapath for the current kernel position: K[ki][kj] * I[orow-ki][ocol-kj].
    always_comb begin
        r_img   = int'(orow_q) - int'(ki_q);
        c_img   = int'(ocol_q) - int'(kj_q);
        in_rng  = (r_img >= 0) && (r_img < I_DIM) && (c_img >= 0) && (c_img < I_DIM);
        img_idx = in_rng ? (r_img * I_DIM + c_img) : 0;
        pix_v   = img_q[IIW'(img_idx)];
        kern_v  = kern_q[KIW'(int'(ki_q) * K_DIM + int'(kj_q))];
        prod    = fp_mul(kern_v, pix_v);
        acc_sum = fp_add(acc_q, prod);
    end

    always_comb begin
        state_d = state_q;
        kern_d  = kern_q;
        img_d   = img_q;
        kcol_d  = kcol_q;
        pix_d   = pix_q;
        acc_d   = acc_q;
        step_d  = step_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        data_d  = data_q;

        case (state_q)
            S_LOAD_K: begin
                if (k_hs) begin
                    // Early last zero-fills the columns not yet received.
                    for (int cc = 0; cc < K_DIM; cc++) begin
                        for (int j = 0; j < K_DIM; j++) begin
                            if (cc == int'(kcol_q)) begin
                                kern_d[KIW'(j * K_DIM + cc)] = kernel_in_data[j*M_BITS +: M_BITS];
                            end else if (kernel_in_last && (cc > int'(kcol_q))) begin
                                kern_d[KIW'(j * K_DIM + cc)] = '0;
                            end
                        end
                    end
                    kcol_d = (kcol_q < K_C) ? (kcol_q + 16'd1) : kcol_q;
                    if (kernel_in_last) begin
                        state_d = S_LOAD_I;
                        kcol_d  = 16'd0;
                        pix_d   = 16'd0;
                    end
                end
            end
            S_LOAD_I: begin
                if (i_hs) begin
                    for (int p = 0; p < II; p++) begin
                        if (p == int'(pix_q)) begin
                            img_d[IIW'(p)] = img_in_data;
                        end else if (img_in_last && (p > int'(pix_q))) begin
                            img_d[IIW'(p)] = '0;
                        end
                    end
                    pix_d = (pix_q < II_C) ? (pix_q + 16'd1) : pix_q;
                    if (img_in_last) begin
                        state_d = S_COMPUTE;
                        pix_d   = 16'd0;
                        acc_d   = '0;
                        step_d  = 16'd0;
                        ki_d    = 16'd0;
                        kj_d    = 16'd0;
                        orow_d  = 16'd0;
                        ocol_d  = 16'd0;
                    end
                end
            end
            S_COMPUTE: begin
                if (step_q < KK_C) begin
                    // Out-of-image positions still spend their cycle.
                    if (in_rng) begin
                        acc_d = acc_sum;
                    end
                    step_d = step_q + 16'd1;
                    if (kj_q == KM1_C) begin
                        kj_d = 16'd0;
                        ki_d = ki_q + 16'd1;
                    end else begin
                        kj_d = kj_q + 16'd1;
                    end
                end else begin
                    state_d = S_OUTPUT;
                    data_d  = acc_q;
                end
            end
            S_OUTPUT: begin
                if (o_hs) begin
                    if (orow_q == OM1_C && ocol_q == OM1_C) begin
                        state_d = S_LOAD_K;
                        orow_d  = 16'd0;
                        ocol_d  = 16'd0;
                        kcol_d  = 16'd0;
                    end else begin
                        state_d = S_COMPUTE;
                        acc_d   = '0;
                        step_d  = 16'd0;
                        ki_d    = 16'd0;
                        kj_d    = 16'd0;
                        if (ocol_q == OM1_C) begin
                            ocol_d = 16'd0;
                            orow_d = orow_q + 16'd1;
                        end else begin
                            ocol_d = ocol_q + 16'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_LOAD_K;
            end
        endcase

        kready_d = (state_d == S_LOAD_K);
        iready_d = (state_d == S_LOAD_I);
        ovalid_d = (state_d == S_OUTPUT);
        olast_d  = (state_d == S_OUTPUT) && (orow_d == OM1_C) && (ocol_d == OM1_C);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= S_LOAD_K;
            kready_q <= 1'b0;
            iready_q <= 1'b0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            data_q   <= '0;
            acc_q    <= '0;
            kcol_q   <= 16'd0;
            pix_q    <= 16'd0;
            step_q   <= 16'd0;
            ki_q     <= 16'd0;
            kj_q     <= 16'd0;
            orow_q   <= 16'd0;
            ocol_q   <= 16'd0;
            for (int n = 0; n < KK; n++) begin
                kern_q[n] <= '0;
            end
            for (int n = 0; n < II; n++) begin
                img_q[n] <= '0;
            end
        end else begin
            state_q  <= state_d;
            kready_q <= kready_d;
            iready_q <= iready_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            kcol_q   <= kcol_d;
            pix_q    <= pix_d;
            step_q   <= step_d;
            ki_q     <= ki_d;
            kj_q     <= kj_d;
            orow_q   <= orow_d;
            ocol_q   <= ocol_d;
            kern_q   <= kern_d;
            img_q    <= img_d;
        end
    end

    assign kernel_in_ready = kready_q;
    assign img_in_ready    = iready_q;
    assign out_valid       = ovalid_q;
    assign out_last        = olast_q;
    assign out_data        = data_q;

endmodule

// File: tb/tb_wrapper.sv
// tb/tb_wrapper.sv - randomized self-checking bench for the fp16 convolution wrapper

module tb_wrapper;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] img_in_data;
    logic        img_in_valid;
    logic        img_in_last;
    logic        img_in_ready;
    logic [47:0] kernel_in_data;
    logic        kernel_in_valid;
    logic        kernel_in_last;
    logic        kernel_in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    always #5 clk = ~clk;

    wrapper #(.K_DIM(3), .I_DIM(3), .M_BITS(16)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .img_in_data     (img_in_data),
        .img_in_valid    (img_in_valid),
        .img_in_last     (img_in_last),
        .img_in_ready    (img_in_ready),
        .kernel_in_data  (kernel_in_data),
        .kernel_in_valid (kernel_in_valid),
        .kernel_in_last  (kernel_in_last),
        .kernel_in_ready (kernel_in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .out_ready       (out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    int nan_cnt = 0;

    logic [47:0] kq[$];
    logic [15:0] iq[$];
    logic [15:0] exp_q[25];
    logic [15:0] got_q[25];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if ((kernel_in_ready && img_in_ready) || (out_valid && (kernel_in_ready || img_in_ready))) viol++;
        if (out_valid && out_data[14:10] == 5'd31 && out_data[9:0] != 10'd0) nan_cnt++;
    end

    // ---------------- reference model (real arithmetic, truncating build) ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) return 0.0;
        v = (1024.0 + real'(h[9:0])) / 1024.0 * pow2(int'(h[14:10]) - 15);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input logic s, input real ax);
        int e;
        int m;
        if (ax < pow2(-14)) return {s, 15'd0};
        if (ax >= 65536.0) return {s, 15'h7C00};
        e = -14;
        while (ax >= pow2(e + 1)) e++;
        m = int'($floor(ax / pow2(e) * 1024.0)) - 1024;
        return {s, 5'(e + 15), 10'(m)};
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        logic s = a[15] ^ b[15];
        real  x;
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
        if (a[14:10] == 5'd31 || b[14:10] == 5'd31) return {s, 15'h7C00};
        x = h2r(a) * h2r(b);
        return r2h(s, (x < 0.0) ? -x : x);
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
        real x;
        if (a[14:10] == 5'd31 || b[14:10] == 5'd31)
            return (a[14:0] >= b[14:0]) ? {a[15], 15'h7C00} : {b[15], 15'h7C00};
        x = h2r(a) + h2r(b);
        if (x == 0.0) return 16'h0000;
        return r2h(x < 0.0, (x < 0.0) ? -x : x);
    endfunction

    task automatic build_model();
        logic [15:0] km[3][3];
        logic [15:0] im[3][3];
        logic [47:0] beat;
        logic [15:0] acc;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) begin km[i][j] = 16'h0; im[i][j] = 16'h0; end
        for (int c = 0; c < 3 && c < kq.size(); c++) begin
            beat = kq[c];
            for (int j = 0; j < 3; j++) km[j][c] = beat[j*16 +: 16];
        end
        for (int p = 0; p < 9 && p < iq.size(); p++) im[p/3][p%3] = iq[p];
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) begin
            acc = 16'h0000;
            for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++)
                if (r - i >= 0 && r - i < 3 && c - j >= 0 && c - j < 3)
                    acc = m_add(acc, m_mul(km[i][j], im[r-i][c-j]));
            exp_q[r*5 + c] = acc;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic push_k(input logic [47:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        kernel_in_data = d; kernel_in_valid = 1'b1; kernel_in_last = l;
        while (!kernel_in_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("k_ready_timeout", t, 0);
        @(posedge clk);
    endtask

    task automatic push_i(input logic [15:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        kernel_in_valid = 1'b0;
        img_in_data = d; img_in_valid = 1'b1; img_in_last = l;
        while (!img_in_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("i_ready_timeout", t, 0);
        @(posedge clk);
    endtask

    task automatic send_frame();
        for (int b = 0; b < kq.size(); b++) push_k(kq[b], b == kq.size() - 1);
        for (int p = 0; p < iq.size(); p++) push_i(iq[p], p == iq.size() - 1);
        #1 img_in_valid = 1'b0; kernel_in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int stall);
        int cnt;
        int bad;
        for (int n = 0; n < 25; n++) begin
            cnt = 0;
            do begin @(posedge clk); #1; cnt++; end while (!out_valid && cnt < 200);
            check($sformatf("%s_lat%0d", tag, n), cnt, 10);
            if (n == 0 && stall > 0) begin
                bad = 0;
                repeat (stall) begin
                    @(posedge clk); #1;
                    if (!out_valid || out_data !== exp_q[0]) bad++;
                end
                check($sformatf("%s_stall_hold", tag), bad, 0);
            end
            got_q[n] = out_data;
            check($sformatf("%s_o%0d", tag, n), out_data, exp_q[n]);
            check($sformatf("%s_last%0d", tag, n), out_last, n == 24);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        check($sformatf("%s_back_to_loadk", tag), kernel_in_ready, 1);
    endtask

    function automatic logic [15:0] rand_h();
        int r = $urandom_range(0, 9);
        if (r == 0) return 16'h0000;
        return {1'($urandom_range(0, 1)), 5'($urandom_range(8, 21)), 10'($urandom)};
    endfunction

    task automatic load_ref_frame();
        logic [15:0] kv[9] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                               16'h4600, 16'h4700, 16'h4800, 16'h4880};
        logic [15:0] iv[9] = '{16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880,
                               16'h4900, 16'h4980, 16'h4A00, 16'h4A80};
        kq.delete(); iq.delete();
        for (int c = 0; c < 3; c++) kq.push_back({kv[3*c+2], kv[3*c+1], kv[3*c]});
        for (int p = 0; p < 9; p++) iq.push_back(iv[p]);
    endtask

    initial begin
        rstn = 1'b1; out_ready = 1'b0;
        img_in_data = '0; img_in_valid = 1'b0; img_in_last = 1'b0;
        kernel_in_data = '0; kernel_in_valid = 1'b0; kernel_in_last = 1'b0;

        // reset state
        #12;
        check("rst_kready", kernel_in_ready, 0);
        check("rst_iready", img_in_ready, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_olast", out_last, 0);
        check("rst_odata", out_data, 0);
        @(posedge clk); #1 rstn = 1'b0;
        #1 check("rel_kready_low", kernel_in_ready, 0);
        @(posedge clk); #1;
        check("rel_kready_rise", kernel_in_ready, 1);

        // reference frame, first output held for 20 cycles
        load_ref_frame(); build_model();
        send_frame();
        collect("A", 20);
        check("A_O00", got_q[0], 16'h4500);
        check("A_O01", got_q[1], 16'h4E80);
        check("A_O44", got_q[24], 16'h5750);

        // 13 image beats: extras discarded
        load_ref_frame();
        for (int p = 0; p < 4; p++) iq.push_back(rand_h());
        build_model();
        send_frame();
        collect("B", 0);
        check("B_O00", got_q[0], 16'h4500);
        check("B_O44", got_q[24], 16'h5750);

        // image last on first beat
        load_ref_frame();
        iq.delete(); iq.push_back(16'h4500);
        build_model();
        send_frame();
        collect("C", 0);
        check("C_O00", got_q[0], 16'h4500);
        check("C_O01", got_q[1], 16'h4D00);
        check("C_O22", got_q[12], 16'h51A0);
        check("C_O33", got_q[18], 16'h0000);

        // reset in the middle of COMPUTE
        load_ref_frame(); build_model();
        send_frame();
        repeat (4) @(posedge clk);
        #1 rstn = 1'b1;
        #1 check("mid_rst_ovalid", out_valid, 0);
        check("mid_rst_kready", kernel_in_ready, 0);
        check("mid_rst_odata", out_data, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_kready_rise", kernel_in_ready, 1);
        send_frame();
        collect("R", 0);

        // saturation: every element is the largest finite value
        kq.delete(); iq.delete();
        for (int c = 0; c < 3; c++) kq.push_back({3{16'h7BFF}});
        for (int p = 0; p < 9; p++) iq.push_back(16'h7BFF);
        build_model();
        send_frame();
        collect("S", 0);
        check("S_O00", got_q[0], 16'h7C00);

        // randomized frames, including early/extra kernel beats and early image last
        for (int f = 0; f < 6; f++) begin
            int nk = $urandom_range(1, 5);
            int ni = $urandom_range(1, 12);
            kq.delete(); iq.delete();
            for (int b = 0; b < nk; b++) kq.push_back({rand_h(), rand_h(), rand_h()});
            for (int p = 0; p < ni; p++) iq.push_back(rand_h());
            build_model();
            send_frame();
            collect($sformatf("RND%0d", f), $urandom_range(0, 3));
        end

        check("ready_exclusive", viol, 0);
        check("no_nan", nan_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wrapper.md
WRAPPER -- requirements
Module: wrapper

Interface
REQ-001 SHALL have parameter K_DIM, default 3, kernel dimension (square kernel).
REQ-002 SHALL have parameter I_DIM, default 3, image dimension (square image).
REQ-003 SHALL have parameter M_BITS, default 16, element width (IEEE binary16); only 16 is supported.
REQ-004 SHALL have port clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports img_in_data input M_BITS, img_in_valid input 1, img_in_last input 1, img_in_ready output 1: AXI-Stream image slave, one pixel per beat.
REQ-007 SHALL have ports kernel_in_data input K_DIM*M_BITS, kernel_in_valid input 1, kernel_in_last input 1, kernel_in_ready output 1: AXI-Stream kernel slave, one kernel column per beat, lane j at bits [j*M_BITS +: M_BITS].
REQ-008 SHALL have ports out_data output M_BITS, out_valid output 1, out_last output 1, out_ready input 1: AXI-Stream result master.

Function
REQ-009 SHALL transfer on any stream only when valid and ready are both high at a rising edge.
REQ-010 SHALL use states LOAD_K -> LOAD_I -> COMPUTE -> OUTPUT -> (COMPUTE, or LOAD_K after the last output).
REQ-011 LOAD_K: kernel_in_ready=1. Beat c writes K[j][c] from lane j. Kernel beats beyond K_DIM are discarded. If last arrives before beat K_DIM, the remaining columns are 0. The block moves to LOAD_I on the last beat.
REQ-012 LOAD_I: img_in_ready=1. Pixels are stored row-major as I[r][c]. Pixels beyond I_DIM*I_DIM are discarded. If last arrives early, the remaining pixels are 0. The block moves to COMPUTE on the last beat.
REQ-013 SHALL compute the full 2-D convolution, O_DIM=K_DIM+I_DIM-1: O[r][c] = sum over i,j of K[i][j]*I[r-i][c-j], with out-of-range image terms omitted. Outputs are produced row-major.
REQ-014 SHALL accumulate from +0, in i-major then j-major order, one kernel position per cycle. Omitted positions still consume a cycle. out_valid asserts exactly K_DIM*K_DIM+1 cycles after COMPUTE entry.
REQ-015 OUTPUT: out_valid=1. out_data and out_last stay stable until the handshake. out_last=1 only on element O_DIM*O_DIM-1. After the handshake the block returns to COMPUTE for the next element; after the last element it returns to LOAD_K.
REQ-016 fp16 multiply:
- sign = XOR of the input signs; exponent = sum of exponents minus 15; 11x11-bit significand product, normalized.
- An exponent field of 0 on either input is treated as zero (flush to zero).
- A result that underflows flushes to signed zero.
- Overflow, or an input exponent field of 31, saturates to infinity (exponent 31, mantissa 0).
REQ-017 fp16 add:
- Align the smaller operand, add or subtract, normalize.
- An exact-zero result is +0.
- Overflow saturates to infinity.
- If either input is infinite, the result is infinity with the sign of the larger-magnitude operand.
- No NaN is ever produced.
REQ-018 The rounding of the multiply and the add SHALL follow REQ-025 and REQ-026.
REQ-019 kernel_in_ready and img_in_ready SHALL never be high at the same time, and SHALL be low while out_valid is high.

Reset
REQ-020 While rstn=1 the block SHALL immediately force: state=LOAD_K; img_in_ready, kernel_in_ready, out_valid and out_last all 0; out_data=0; kernel store, image store and accumulator all 0.
REQ-021 Reset asserted mid-operation SHALL abort the current frame; no partial results survive.
REQ-022 kernel_in_ready SHALL rise on the first clk edge after rstn deasserts.

Configuration
REQ-023 Rounding mode SHALL be selected by the macro WRAPPER_ROUND_NEAREST_EN.
REQ-024 A given build SHALL use one rounding mode for both the multiply and the add.
REQ-025 With WRAPPER_ROUND_NEAREST_EN defined, the multiply and the add SHALL round to nearest, ties to even.
REQ-026 Without WRAPPER_ROUND_NEAREST_EN, the multiply and the add SHALL truncate (round toward zero).
REQ-027 Exactly representable results SHALL be identical in both modes.

Verification
REQ-028 Kernel: 3 beats, beat c lane j = fp16(3c+j+1) (c=0: 0x3C00,0x4000,0x4200). Image: fp16(5..13) row-major. Required response: 25 outputs; O[0][0]=0x4500 (5), O[0][1]=0x4E80 (26), O[4][4]=0x5750 (117); out_last only on the 25th.
REQ-029 Same kernel; 13 image beats, last on the 13th. Required response: beats 10-13 accepted and discarded, outputs identical to REQ-028.
REQ-030 Image last on beat 1 (value 5), all other pixels 0. Required response: O[r][c] = 5*K[r][c] for r,c<3, and 0 elsewhere.
REQ-031 out_ready held low for 20 cycles at the first output. Required response: out_valid stays 1, out_data holds 0x4500, no other stream is ready.
REQ-032 rstn pulsed high mid-COMPUTE. Required response: out_valid 0 immediately; kernel_in_ready 1 the cycle after release; a new frame gives the REQ-028 results.
REQ-033 Kernel all 0x7BFF, image all 0x7BFF. Required response: O[0][0]=0x7C00 (saturated infinity), never a NaN.
